// File: rtl/uart_cmd_parser_if.sv
// Command port carrying validated register writes from uart_cmd_parser
// to the camera register-programming master.
interface uart_cmd_parser_if;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        valid;
  logic        ready;

  modport master (output addr, output data, output valid, input ready);
  modport slave  (input addr, input data, input valid, output ready);
endinterface

// File: rtl/uart_cmd_parser.sv
// Frames UART bytes into register-write commands: SYNC, ADDR, DATA_H, DATA_L[, CSUM].
// Optional feature macro: UART_CMD_CHECKSUM_EN adds the trailing XOR checksum byte and its check.
module uart_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rxd_data_i,
  input  logic              rxd_ready_i,
  uart_cmd_parser_if.master cmd,
  output logic              err_o,
  output logic [7:0]        err_count_o,
  output logic              busy_o
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DH    = 3'd2,
    ST_DL    = 3'd3,
`ifdef UART_CMD_CHECKSUM_EN
    ST_CSUM  = 3'd4,
`endif
    ST_ISSUE = 3'd5
  } state_e;

`ifdef UART_CMD_CHECKSUM_EN
  function automatic logic [7:0] csum8(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c);
    return a ^ b ^ c;
  endfunction
`endif

  state_e      state_q;
  logic        rdy_q;
  logic [15:0] tmo_q;
  logic [7:0]  addr_q;
  logic [7:0]  dh_q;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]  dl_q;
`endif
  logic [7:0]  cmd_addr_q;
  logic [15:0] cmd_data_q;
  logic        cmd_valid_q;
  logic        err_q;
  logic [7:0]  err_count_q;
  logic        busy_q;

  logic rise_s;
  logic in_pkt_s;
  logic timeout_s;
  logic overrun_s;
  logic csum_bad_s;
  logic err_s;
  logic hs_s;

  // Byte-arrival edge detect and the three mutually exclusive error causes.
  always_comb begin
    rise_s     = rxd_ready_i & ~rdy_q;
    hs_s       = cmd_valid_q & cmd.ready;
    in_pkt_s   = 1'b0;
    overrun_s  = 1'b0;
    csum_bad_s = 1'b0;
    case (state_q)
      ST_ADDR, ST_DH, ST_DL: in_pkt_s = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
      ST_CSUM: begin
        in_pkt_s   = 1'b1;
        csum_bad_s = rise_s & (rxd_data_i != csum8(addr_q, dh_q, dl_q));
      end
`endif
      ST_ISSUE: overrun_s = rise_s;
      default:  in_pkt_s = 1'b0;
    endcase
    // A byte landing in the expiry cycle wins over the timeout.
    timeout_s = in_pkt_s & ~rise_s & (tmo_q == TMO_LAST);
    err_s     = timeout_s | overrun_s | csum_bad_s;
  end

  // Packet FSM with registered command, error and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b1;
      tmo_q       <= 16'd0;
      addr_q      <= 8'd0;
      dh_q        <= 8'd0;
`ifdef UART_CMD_CHECKSUM_EN
      dl_q        <= 8'd0;
`endif
      cmd_addr_q  <= 8'd0;
      cmd_data_q  <= 16'd0;
      cmd_valid_q <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= 8'd0;
      busy_q      <= 1'b0;
    end else begin
      rdy_q <= rxd_ready_i;
      err_q <= err_s;
      if (err_s && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end

      if (rise_s || !in_pkt_s || timeout_s) begin
        tmo_q <= 16'd0;
      end else begin
        tmo_q <= tmo_q + 16'd1;
      end

      if (timeout_s) begin
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise_s && (rxd_data_i == SYNC_BYTE)) begin
              state_q <= ST_ADDR;
              busy_q  <= 1'b1;
            end
          end
          ST_ADDR: begin
            if (rise_s) begin
              addr_q  <= rxd_data_i;
              state_q <= ST_DH;
            end
          end
          ST_DH: begin
            if (rise_s) begin
              dh_q    <= rxd_data_i;
              state_q <= ST_DL;
            end
          end
          ST_DL: begin
            if (rise_s) begin
`ifdef UART_CMD_CHECKSUM_EN
              dl_q        <= rxd_data_i;
              state_q     <= ST_CSUM;
`else
              cmd_addr_q  <= addr_q;
              cmd_data_q  <= {dh_q, rxd_data_i};
              cmd_valid_q <= 1'b1;
              state_q     <= ST_ISSUE;
`endif
            end
          end
`ifdef UART_CMD_CHECKSUM_EN
          ST_CSUM: begin
            if (rise_s) begin
              if (csum_bad_s) begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end else begin
                cmd_addr_q  <= addr_q;
                cmd_data_q  <= {dh_q, dl_q};
                cmd_valid_q <= 1'b1;
                state_q     <= ST_ISSUE;
              end
            end
          end
`endif
          ST_ISSUE: begin
            // Overrun bytes are dropped here; only the handshake leaves ISSUE.
            if (hs_s) begin
              cmd_valid_q <= 1'b0;
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
            end
          end
          default: begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cmd.addr    = cmd_addr_q;
  assign cmd.data    = cmd_data_q;
  assign cmd.valid   = cmd_valid_q;
  assign err_o       = err_q;
  assign err_count_o = err_count_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed scenarios plus a randomized
// byte stream scored against a packet-level reference model.
module tb_uart_cmd_parser;
  localparam int TMO = 100;
`ifdef UART_CMD_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int PKT_LEN = CSUM_EN ? 5 : 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rxd_data;
  logic       rxd_ready;
  logic       err;
  logic [7:0] err_count;
  logic       busy;

  uart_cmd_parser_if cmd_if();

  uart_cmd_parser #(.SYNC_BYTE(8'hAA), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rxd_data_i(rxd_data), .rxd_ready_i(rxd_ready),
    .cmd(cmd_if), .err_o(err), .err_count_o(err_count), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_errs = 0;

  // Monitor: completed handshakes and ERR pulses, sampled mid-cycle.
  logic [23:0] got_q[$];
  int          err_seen = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_if.valid && cmd_if.ready) got_q.push_back({cmd_if.addr, cmd_if.data});
      if (err) err_seen++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    rxd_data  = b;
    rxd_ready = 1'b1;
    repeat (hi) tick();
    rxd_ready = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [15:0] d, input logic corrupt,
                          input int g0);
    logic [7:0] cs;
    cs = a ^ d[15:8] ^ d[7:0];
    if (corrupt) cs = cs ^ 8'h01;
    send_byte(8'hAA, 1, g0 - 1);
    send_byte(a, 1, 2);
    send_byte(d[15:8], 1, 2);
    send_byte(d[7:0], 1, 2);
    if (CSUM_EN) send_byte(cs, 1, 2);
  endtask

  task automatic test_reset();
    int base_err;
    cmd_if.ready = 1'b1;
    rxd_data  = 8'hAA;
    rxd_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) tick();
    tests_run++;
    if ({cmd_if.addr, cmd_if.data, cmd_if.valid, err, err_count, busy} !== 35'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got %h expected 0",
               {cmd_if.addr, cmd_if.data, cmd_if.valid, err, err_count, busy});
    end
    rst_n = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    tests_run++;
    if ({busy, err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL stale_ready_at_release: busy,err got %b expected 00", {busy, err});
    end
    rxd_ready = 1'b0;
    repeat (2) tick();
    base_err = err_seen;
    send_byte(8'hAA, 1, 2);
    send_byte(8'h12, 1, 2);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_mid_packet: got %b expected 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({cmd_if.addr, cmd_if.data, cmd_if.valid, err, err_count, busy} !== 35'd0) begin
      tests_failed++;
      $display("FAIL async_reset_mid_packet: got %h expected 0",
               {cmd_if.addr, cmd_if.data, cmd_if.valid, err, err_count, busy});
    end
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    tests_run++;
    if ({busy, err, err_count} !== 10'd0 || err_seen != base_err) begin
      tests_failed++;
      $display("FAIL reset_abort_no_err: busy,err,cnt got %h errs %0d expected 0 errs %0d",
               {busy, err, err_count}, err_seen, base_err);
    end
    exp_errs = 0;
  endtask

  task automatic test_basic();
    int base_cmd, base_err;
    logic [7:0] last;
    base_cmd = got_q.size();
    base_err = err_seen;
    cmd_if.ready = 1'b1;
    rxd_data  = 8'hAA;
    rxd_ready = 1'b1;
    tick();
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL busy_after_sync: got %b expected 1", busy);
    end
    rxd_ready = 1'b0;
    repeat (2) tick();
    send_byte(8'h12, 1, 2);
    send_byte(8'h34, 1, 2);
    if (CSUM_EN) begin
      send_byte(8'h56, 1, 2);
      last = 8'h70;
    end else begin
      last = 8'h56;
    end
    rxd_data  = last;
    rxd_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (cmd_if.valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL valid_before_last_edge: got %b expected 0", cmd_if.valid);
    end
    tick();
    @(negedge clk);
    tests_run++;
    if ({cmd_if.valid, cmd_if.addr, cmd_if.data} !== {1'b1, 8'h12, 16'h3456}) begin
      tests_failed++;
      $display("FAIL basic_cmd: got v=%b a=%h d=%h expected v=1 a=12 d=3456",
               cmd_if.valid, cmd_if.addr, cmd_if.data);
    end
    rxd_ready = 1'b0;
    tick();
    @(negedge clk);
    tests_run++;
    if ({cmd_if.valid, busy, cmd_if.addr, cmd_if.data} !== {2'b00, 8'h12, 16'h3456}) begin
      tests_failed++;
      $display("FAIL basic_after_hs: got v=%b busy=%b a=%h d=%h expected v=0 busy=0 a=12 d=3456",
               cmd_if.valid, busy, cmd_if.addr, cmd_if.data);
    end
    tests_run++;
    if (got_q.size() != base_cmd + 1 || err_seen != base_err || err_count !== 8'(exp_errs)) begin
      tests_failed++;
      $display("FAIL basic_counts: cmds %0d errs %0d cnt %0d expected cmds %0d errs %0d cnt %0d",
               got_q.size() - base_cmd, err_seen - base_err, err_count, 1, 0, exp_errs);
    end
  endtask

`ifdef UART_CMD_CHECKSUM_EN
  task automatic test_bad_csum();
    int base_cmd, base_err;
    base_cmd = got_q.size();
    base_err = err_seen;
    send_pkt(8'h12, 16'h3456, 1'b1, 3);
    repeat (3) tick();
    exp_errs++;
    tests_run++;
    if (got_q.size() != base_cmd || err_seen != base_err + 1 || err_count !== 8'(exp_errs)
        || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL bad_csum: cmds %0d errs %0d cnt %0d busy %b expected 0 1 %0d 0",
               got_q.size() - base_cmd, err_seen - base_err, err_count, busy, exp_errs);
    end
    send_pkt(8'hAB, 16'hCDEF, 1'b0, 3);
    tick();
    tests_run++;
    if (got_q.size() != base_cmd + 1 || got_q[got_q.size() - 1] !== 24'hABCDEF) begin
      tests_failed++;
      $display("FAIL bad_csum_recover: got %0d cmds last %h expected 1 cmd ABCDEF",
               got_q.size() - base_cmd, got_q[got_q.size() - 1]);
    end
  endtask
`endif

  task automatic test_stray();
    int base_cmd, base_err;
    base_cmd = got_q.size();
    base_err = err_seen;
    send_byte(8'h00, 1, 3);
    send_byte(8'hFF, 2, 2);
    send_pkt(8'h01, 16'h0203, 1'b0, 3);
    tick();
    tests_run++;
    if (got_q.size() != base_cmd + 1 || got_q[got_q.size() - 1] !== 24'h010203
        || err_seen != base_err) begin
      tests_failed++;
      $display("FAIL stray_bytes: cmds %0d last %h errs %0d expected 1 010203 0",
               got_q.size() - base_cmd, got_q[got_q.size() - 1], err_seen - base_err);
    end
  endtask

  task automatic test_timeout();
    int seen_at, base_cmd, base_err;
    send_byte(8'hAA, 1, 2);
    rxd_data  = 8'h12;
    rxd_ready = 1'b1;
    tick();
    rxd_ready = 1'b0;
    seen_at = 0;
    for (int j = 1; j <= TMO + 50 && seen_at == 0; j++) begin
      @(negedge clk);
      if (err) seen_at = j;
    end
    exp_errs++;
    tests_run++;
    if (seen_at != TMO + 1) begin
      tests_failed++;
      $display("FAIL timeout_latency: err at cycle %0d expected %0d", seen_at, TMO + 1);
    end
    tests_run++;
    if (busy !== 1'b0 || err_count !== 8'(exp_errs)) begin
      tests_failed++;
      $display("FAIL timeout_state: busy %b cnt %0d expected 0 %0d", busy, err_count, exp_errs);
    end
    @(negedge clk);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_pulse_width: err got %b expected 0", err);
    end
    base_cmd = got_q.size();
    base_err = err_seen;
    send_pkt(8'h21, 16'h4365, 1'b0, 3);
    send_pkt(8'h12, 16'h3456, 1'b0, TMO);
    tick();
    tests_run++;
    if (got_q.size() != base_cmd + 2 || got_q[got_q.size() - 1] !== 24'h123456
        || got_q[got_q.size() - 2] !== 24'h214365 || err_seen != base_err) begin
      tests_failed++;
      $display("FAIL timeout_recover_and_edge_gap: cmds %0d errs %0d expected 2 0",
               got_q.size() - base_cmd, err_seen - base_err);
    end
  endtask

  task automatic test_overrun();
    int bad, base_err;
    base_err = err_seen;
    cmd_if.ready = 1'b0;
    send_pkt(8'h5A, 16'h1234, 1'b0, 3);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ({cmd_if.valid, busy, cmd_if.addr, cmd_if.data} !== {2'b11, 8'h5A, 16'h1234}) bad++;
      if (i == 50) begin
        rxd_data  = 8'hAA;
        rxd_ready = 1'b1;
      end
      if (i == 53) rxd_ready = 1'b0;
    end
    exp_errs++;
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL overrun_hold: %0d unstable cycles expected 0", bad);
    end
    tests_run++;
    if (err_seen != base_err + 1 || err_count !== 8'(exp_errs)) begin
      tests_failed++;
      $display("FAIL overrun_err: errs %0d cnt %0d expected 1 %0d",
               err_seen - base_err, err_count, exp_errs);
    end
    tick();
    cmd_if.ready = 1'b1;
    tick();
    @(negedge clk);
    tests_run++;
    if ({cmd_if.valid, busy, cmd_if.addr, cmd_if.data} !== {2'b00, 8'h5A, 16'h1234}
        || got_q[got_q.size() - 1] !== 24'h5A1234) begin
      tests_failed++;
      $display("FAIL overrun_handshake: v=%b busy=%b a=%h d=%h expected 0 0 5A 1234",
               cmd_if.valid, busy, cmd_if.addr, cmd_if.data);
    end
    cmd_if.ready = 1'b0;
    send_pkt(8'h66, 16'h7788, 1'b0, 3);
    cmd_if.ready = 1'b1;
    rxd_data  = 8'hAA;
    rxd_ready = 1'b1;
    tick();
    @(negedge clk);
    exp_errs++;
    tests_run++;
    if ({cmd_if.valid, err, busy} !== 3'b010 || got_q[got_q.size() - 1] !== 24'h667788) begin
      tests_failed++;
      $display("FAIL overrun_same_cycle_hs: v,err,busy got %b expected 010", {cmd_if.valid, err, busy});
    end
    rxd_ready = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_random(input int n_items);
    logic [7:0]  sb[$];
    int          sg[$];
    logic [23:0] exp_q[$];
    logic [7:0]  pk[5];
    logic [7:0]  fld[5];
    logic [7:0]  b;
    int          kind, n, g, hi, idx, m_err, base_cmd, base_err;
    base_cmd = got_q.size();
    base_err = err_seen;
    cmd_if.ready = 1'b1;
    for (int p = 0; p < n_items; p++) begin
      kind  = $urandom_range(0, 9);
      pk[0] = 8'hAA;
      pk[1] = 8'($urandom);
      pk[2] = 8'($urandom);
      pk[3] = 8'($urandom);
      pk[4] = pk[1] ^ pk[2] ^ pk[3];
      if (kind == 6) pk[4] = pk[4] ^ 8'(1 << $urandom_range(0, 7));
      if (kind == 7) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          if (b == 8'hAA) b = 8'h55;
          sb.push_back(b);
          sg.push_back($urandom_range(2, 8));
        end
      end else begin
        n = (kind == 8) ? $urandom_range(1, PKT_LEN - 1) : PKT_LEN;
        for (int k = 0; k < n; k++) begin
          sb.push_back(pk[k]);
          sg.push_back($urandom_range(2, 8));
        end
        if (kind == 8) sg[sg.size() - 1] = TMO + $urandom_range(1, 4);
        if (kind == 9) sg[sg.size() - PKT_LEN + $urandom_range(0, PKT_LEN - 2)] = TMO;
      end
    end
    for (int i = 0; i < sb.size(); i++) begin
      g  = sg[i];
      hi = $urandom_range(1, (g > 4) ? 3 : g - 1);
      send_byte(sb[i], hi, g - hi);
    end
    repeat (TMO + 10) tick();

    // Reference: walk the byte stream packet by packet, using the inter-byte gaps.
    idx   = 0;
    m_err = 0;
    for (int i = 0; i < sb.size(); i++) begin
      if (i > 0 && idx > 0 && sg[i - 1] > TMO) begin
        m_err++;
        idx = 0;
      end
      if (idx == 0) begin
        if (sb[i] == 8'hAA) idx = 1;
      end else begin
        fld[idx] = sb[i];
        idx++;
        if (idx == PKT_LEN) begin
          if (!CSUM_EN || fld[4] == (fld[1] ^ fld[2] ^ fld[3]))
            exp_q.push_back({fld[1], fld[2], fld[3]});
          else
            m_err++;
          idx = 0;
        end
      end
    end
    if (idx > 0) m_err++;
    exp_errs += m_err;

    tests_run++;
    if (got_q.size() - base_cmd != exp_q.size()) begin
      tests_failed++;
      $display("FAIL random_cmd_count: got %0d expected %0d", got_q.size() - base_cmd, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base_cmd + i < got_q.size(); i++) begin
      tests_run++;
      if (got_q[base_cmd + i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL random_cmd[%0d]: got %h expected %h", i, got_q[base_cmd + i], exp_q[i]);
      end
    end
    tests_run++;
    if (err_seen - base_err != m_err || err_count !== 8'(exp_errs)) begin
      tests_failed++;
      $display("FAIL random_errs: pulses %0d cnt %0d expected %0d %0d",
               err_seen - base_err, err_count, m_err, exp_errs);
    end
  endtask

  task automatic test_saturation();
    cmd_if.ready = 1'b0;
    send_pkt(8'h77, 16'h0102, 1'b0, 3);
    for (int i = 0; i < 260; i++) send_byte(8'($urandom), 1, 1);
    tick();
    tests_run++;
    if (err_count !== 8'hFF || cmd_if.valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_count_saturate: cnt %h valid %b expected FF 1", err_count, cmd_if.valid);
    end
    cmd_if.ready = 1'b1;
    repeat (2) tick();
    tests_run++;
    if (got_q[got_q.size() - 1] !== 24'h770102 || cmd_if.valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL saturate_handshake: last %h valid %b expected 770102 0",
               got_q[got_q.size() - 1], cmd_if.valid);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    rxd_ready = 1'b0;
    rxd_data  = 8'h00;
    cmd_if.ready = 1'b1;
    test_reset();
    test_basic();
`ifdef UART_CMD_CHECKSUM_EN
    test_bad_csum();
`endif
    test_stray();
    test_timeout();
    test_overrun();
    test_random(40);
    test_random(40);
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
